// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - arbiter states and cathode patterns for the shared seven-segment display
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry i holds the active-low pattern {Ca..Cg} for hex digit i (index 15 listed first)
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0001100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

endpackage

// File: rtl/ssd_hex_decode.sv
// rtl/ssd_hex_decode.sv - hex nibble to active-low seven-segment cathodes
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/ssd_share_ctrl.sv
// rtl/ssd_share_ctrl.sv - two-requester frame-granular sharing of a 4-digit multiplexed display
// Optional macro SSD_DP_OWNER_EN lights the dot point on the digit matching the owner index.
module ssd_share_ctrl
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV    = 262144,
  parameter int BLANK_CYC   = 4096,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        ClkPort,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [15:0] dig0,
  input  logic        req1,
  input  logic [15:0] dig1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] HOLD      = FW'(HOLD_FRAMES);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic          slot_end;
  logic          frame_end;
  logic          in_blank;

  state_t        state;
  state_t        state_n;
  logic [FW-1:0] frames_owned;
  logic          rr_last;
  logic [15:0]   frame_reg;
  logic          new_grant;

  logic          lit;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);
  assign in_blank  = (int'(slot_cnt) < BLANK_CYC);

  always_ff @(posedge ClkPort or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_n = rr_last ? OWN0 : OWN1;
        else if (req0)     state_n = OWN0;
        else if (req1)     state_n = OWN1;
      end
      OWN0: begin
        if (!req0)                                state_n = req1 ? OWN1 : IDLE;
        else if (req1 && (frames_owned >= HOLD))  state_n = OWN1;
      end
      OWN1: begin
        if (!req1)                                state_n = req0 ? OWN0 : IDLE;
        else if (req0 && (frames_owned >= HOLD))  state_n = OWN0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign new_grant = (state_n != IDLE) && (state_n != state);

  // Everything owner-related moves only on the edge that closes a frame
  always_ff @(posedge ClkPort or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      frames_owned <= '0;
      rr_last      <= 1'b1;
      frame_reg    <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
    end else if (frame_end) begin
      state <= state_n;
      gnt0  <= (state_n == OWN0);
      gnt1  <= (state_n == OWN1);
      if (state_n == IDLE) begin
        frames_owned <= '0;
      end else if (new_grant) begin
        frames_owned <= FW'(1);
        rr_last      <= (state_n == OWN1);
      end else if (frames_owned < HOLD) begin
        frames_owned <= frames_owned + FW'(1);
      end
      if (state_n == OWN0)      frame_reg <= dig0;
      else if (state_n == OWN1) frame_reg <= dig1;
    end
  end

  assign lit    = (state != IDLE) && !in_blank;
  assign nibble = frame_reg[{idx, 2'b00} +: 4];

  ssd_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge ClkPort or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= lit ? ~(4'b0001 << idx) : 4'b1111;
      seg <= lit ? seg_dec : SEG_BLANK;
    end
  end

`ifdef SSD_DP_OWNER_EN
  logic dp_on;
  assign dp_on = lit && (((state == OWN0) && (idx == 2'd0)) ||
                         ((state == OWN1) && (idx == 2'd1)));

  always_ff @(posedge ClkPort or negedge reset_n) begin
    if (!reset_n) dp <= 1'b1;
    else          dp <= !dp_on;
  end
`else
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_ssd_share_ctrl.sv
// tb/tb_ssd_share_ctrl.sv - self-checking bench for ssd_share_ctrl with a frame-level reference model
module tb_ssd_share_ctrl;

  localparam int S  = 8;
  localparam int B  = 2;
  localparam int H  = 2;
  localparam int FR = 4 * S;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] dig0 = '0, dig1 = '0;
  logic        gnt0, gnt1, dp;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_fail   = 0;
  int since    = 0;

  logic [6:0] hexseg [16];

  int          mpos, mown, mfo, mrr;
  logic [15:0] mframe;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  int          e_gnt;

  ssd_share_ctrl #(.SCAN_DIV(S), .BLANK_CYC(B), .HOLD_FRAMES(H)) dut (
    .ClkPort (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .dig0    (dig0),
    .req1    (req1),
    .dig1    (dig1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] gnt_bits(input int owner);
    return (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
  endfunction

  // Reference: position within the frame, owner and its tenure, tracked as plain integers
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mpos = 0; mown = -1; mfo = 0; mrr = 1; mframe = '0;
      e_an = 4'hf; e_seg = 7'h7f; e_dp = 1'b1; e_gnt = -1;
    end else begin
      int  slot, c, newo, other;
      bit  lit;
      bit  [1:0] rq;
      slot = mpos / S;
      c    = mpos % S;
      lit  = (mown >= 0) && (c >= B);
      e_an  = lit ? (4'hf & ~(4'(1) << slot)) : 4'hf;
      e_seg = lit ? hexseg[(mframe >> (4 * slot)) & 16'hf] : 7'h7f;
`ifdef SSD_DP_OWNER_EN
      e_dp = !(lit && (mown == slot));
`else
      e_dp = 1'b1;
`endif
      if (mpos == FR - 1) begin
        rq = {req1, req0};
        if (mown < 0) begin
          if (rq == 2'b11) newo = 1 - mrr;
          else if (rq[0])  newo = 0;
          else if (rq[1])  newo = 1;
          else             newo = -1;
        end else begin
          other = 1 - mown;
          if (rq[mown]) newo = (rq[other] && mfo >= H) ? other : mown;
          else          newo = rq[other] ? other : -1;
        end
        if (newo < 0) mfo = 0;
        else if (newo != mown) begin mfo = 1; mrr = newo; end
        else if (mfo < H) mfo = mfo + 1;
        if (newo == 0) mframe = dig0;
        else if (newo == 1) mframe = dig1;
        mown  = newo;
        e_gnt = newo;
      end
      mpos = (mpos + 1) % FR;
    end
  end

  always @(negedge clk) begin
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("seg", {9'h0, seg}, {9'h0, e_seg});
    chk("dp", {15'h0, dp}, {15'h0, e_dp});
    chk("gnt", {14'h0, gnt1, gnt0}, {14'h0, gnt_bits(e_gnt)});
  end

  task automatic do_reset();
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    since = 0;
  endtask

  task automatic go(input int n);
    repeat (n - since) @(negedge clk);
    since = n;
    #1;
  endtask

  initial begin
    int gexp [8];
    hexseg = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
               7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // No requester: three dark frames
    do_reset();
    #1;
    chk("rst_an", {12'h0, an}, 16'hf);
    chk("rst_seg", {9'h0, seg}, 16'h7f);
    chk("rst_gnt", {14'h0, gnt1, gnt0}, 16'h0);
    go(40); chk("idle_an", {12'h0, an}, 16'hf);
    go(90); chk("idle_seg", {9'h0, seg}, 16'h7f);
            chk("idle_gnt", {14'h0, gnt1, gnt0}, 16'h0);

    // Single owner showing 1234 on digits 3..0
    do_reset();
    req0 = 1'b1; dig0 = 16'h1234;
    go(31); chk("g0_before", {14'h0, gnt1, gnt0}, 16'h0);
    go(32); chk("g0_first", {14'h0, gnt1, gnt0}, 16'h1);
    go(34); chk("blank_an", {12'h0, an}, 16'hf);
    go(35); chk("s0c2_an", {12'h0, an}, 16'he);
            chk("s0c2_seg", {9'h0, seg}, 16'h4c);
    go(40); chk("s0c7_seg", {9'h0, seg}, 16'h4c);
    go(45); chk("s1_seg", {9'h0, seg}, 16'h06);
    // Owner drops mid-frame: current frame keeps the captured digits
    go(48); req0 = 1'b0; dig0 = 16'habcd;
    go(61); chk("s3_an", {12'h0, an}, 16'h7);
            chk("s3_seg", {9'h0, seg}, 16'h4f);
    go(80); chk("drop_an", {12'h0, an}, 16'hf);
            chk("drop_gnt", {14'h0, gnt1, gnt0}, 16'h0);

    // Both requesting: requester 0 first, alternating every HOLD frames
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    gexp = '{0, 0, 1, 1, 2, 2, 1, 1};
    for (int f = 1; f < 8; f++) begin
      go((f - 1) * FR + 16);
      chk("rr_gnt", {14'h0, gnt1, gnt0}, 16'(gexp[f]));
    end

    // Reset mid-frame drops ownership immediately
    do_reset();
    req0 = 1'b1; dig0 = 16'h5678;
    go(52);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_an", {12'h0, an}, 16'hf);
    chk("mid_rst_gnt", {14'h0, gnt1, gnt0}, 16'h0);
    chk("mid_rst_seg", {9'h0, seg}, 16'h7f);
    @(negedge clk);
    reset_n = 1'b1;
    since = 0;
    go(31); chk("regrant_pre", {14'h0, gnt1, gnt0}, 16'h0);
    go(32); chk("regrant", {14'h0, gnt1, gnt0}, 16'h1);

    // Owner 1: dot point follows digit 1 only when the macro is enabled
    do_reset();
    req1 = 1'b1; dig1 = 16'h0f00;
    go(37); chk("dp_d0_an", {12'h0, an}, 16'he);
            chk("dp_d0", {15'h0, dp}, 16'h1);
    go(45); chk("dp_d1_an", {12'h0, an}, 16'hd);
`ifdef SSD_DP_OWNER_EN
            chk("dp_d1", {15'h0, dp}, 16'h0);
`else
            chk("dp_d1", {15'h0, dp}, 16'h1);
`endif

    // Randomized requests and digit changes against the model
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) req0 = ~req0;
      if ($urandom_range(0, 59) == 0) req1 = ~req1;
      if ($urandom_range(0, 9) == 0)  dig0 = 16'($urandom);
      if ($urandom_range(0, 9) == 0)  dig1 = 16'($urandom);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
